// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the lock_stats window statistics block.
//   WIN_W        : width of the requested log2 window field
//   lock_state_e : window sequencer states
package lock_pkg;

  localparam int WIN_W = 3;

  typedef enum logic {
    ST_FIRST = 1'b0,   // next in_tick starts a new window
    ST_ACC   = 1'b1    // window in progress, accumulating samples
  } lock_state_e;

endpackage

// File: rtl/lock_minmax.sv
// lock_minmax: running signed min/max tracker for one window.
// Only instantiated when LOCK_STATS_MINMAX_EN is defined.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   load             : first sample of a window, loads both extrema
//   update           : later sample of a window, compares against extrema
//   din              : signed sample
//   min_nxt, max_nxt : extrema including the current sample (combinational),
//                      so the parent can register them on the completing tick
module lock_minmax #(
  parameter int R = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                update,
  input  logic signed [R-1:0] din,
  output logic signed [R-1:0] min_nxt,
  output logic signed [R-1:0] max_nxt
);

  logic signed [R-1:0] min_q, max_q;

  always_comb begin
    min_nxt = min_q;
    max_nxt = max_q;
    if (load) begin
      min_nxt = din;
      max_nxt = din;
    end else if (update) begin
      if (din < min_q) min_nxt = din;
      if (din > max_q) max_nxt = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_nxt;
      max_q <= max_nxt;
    end
  end

endmodule

// File: rtl/lock_stats.sv
// lock_stats: windowed sum / mean / extrema of a decimated sample stream.
// A window of 2**min(log2_win, M) samples is accumulated; on the last sample
// the result is registered and held with valid until acked. A completion
// while a result is still held and not acked is dropped (sticky overrun).
// Optional feature: define LOCK_STATS_MINMAX_EN to build min/max tracking;
// otherwise min and max read constant 0.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   in, in_tick       : signed sample and its strobe
//   log2_win          : requested log2 window length (latched at window start)
//   clear             : synchronous flush of window, result and flags
//   ack               : consumer accepts held result
//   sum, mean         : window sum (R+M bits) and floor mean
//   min, max          : window extrema
//   valid, overrun    : result held / result dropped (sticky)
//   win_cnt           : number of results loaded, wraps at 255
module lock_stats
  import lock_pkg::*;
#(
  parameter int R = 14,
  parameter int M = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [R-1:0]   in,
  input  logic                  in_tick,
  input  logic [WIN_W-1:0]      log2_win,
  input  logic                  clear,
  input  logic                  ack,
  output logic signed [R+M-1:0] sum,
  output logic signed [R-1:0]   mean,
  output logic signed [R-1:0]   min,
  output logic signed [R-1:0]   max,
  output logic                  valid,
  output logic                  overrun,
  output logic [7:0]            win_cnt
);

  localparam int SW = R + M;
  localparam int CW = M + 1;   // holds sample counts up to 2**M
  localparam logic [WIN_W-1:0] N_MAX = WIN_W'(M);

  lock_state_e          state_q;
  logic [WIN_W-1:0]     n_q;
  logic [CW-1:0]        cnt_q;
  logic signed [SW-1:0] acc_q;

  logic                 starting;
  logic [WIN_W-1:0]     n_win;
  logic signed [SW-1:0] in_ext, acc_nxt;
  logic [CW-1:0]        cnt_nxt;
  logic                 done;
  logic signed [R-1:0]  mean_nxt;

  always_comb begin
    starting = (state_q == ST_FIRST);
    in_ext   = {{M{in[R-1]}}, in};
    n_win    = starting ? ((log2_win > N_MAX) ? N_MAX : log2_win) : n_q;
    acc_nxt  = starting ? in_ext : acc_q + in_ext;
    cnt_nxt  = starting ? CW'(1) : cnt_q + CW'(1);
    done     = in_tick && (cnt_nxt == (CW'(1) << n_win));
    // arithmetic shift gives floor division for negative sums
    mean_nxt = R'(acc_nxt >>> n_win);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FIRST;
      n_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum     <= '0;
      mean    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      win_cnt <= '0;
    end else if (clear) begin
      state_q <= ST_FIRST;
      n_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum     <= '0;
      mean    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      win_cnt <= '0;
    end else begin
      if (in_tick) begin
        acc_q   <= acc_nxt;
        cnt_q   <= cnt_nxt;
        n_q     <= n_win;
        state_q <= done ? ST_FIRST : ST_ACC;
      end
      if (done) begin
        if (!valid || ack) begin
          sum     <= acc_nxt;
          mean    <= mean_nxt;
          valid   <= 1'b1;
          win_cnt <= win_cnt + 8'd1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef LOCK_STATS_MINMAX_EN
  logic signed [R-1:0] min_nxt, max_nxt;

  lock_minmax #(.R(R)) u_minmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (in_tick && starting && !clear),
    .update  (in_tick && !starting && !clear),
    .din     (in),
    .min_nxt (min_nxt),
    .max_nxt (max_nxt)
  );

  // result extrema follow the same load/hold rule as sum and mean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min <= '0;
      max <= '0;
    end else if (clear) begin
      min <= '0;
      max <= '0;
    end else if (done && (!valid || ack)) begin
      min <= min_nxt;
      max <= max_nxt;
    end
  end
`else
  assign min = '0;
  assign max = '0;
`endif

endmodule

// File: tb/tb_lock_stats.sv
module tb_lock_stats;
  localparam int R = 14;
  localparam int M = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic signed [R-1:0]   in_v = '0;
  logic                  in_tick = 1'b0;
  logic [2:0]            log2_win = '0;
  logic                  clear = 1'b0;
  logic                  ack = 1'b0;
  logic signed [R+M-1:0] sum;
  logic signed [R-1:0]   mean, min, max;
  logic                  valid, overrun;
  logic [7:0]            win_cnt;

  lock_stats #(.R(R), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_v), .in_tick(in_tick), .log2_win(log2_win),
    .clear(clear), .ack(ack), .sum(sum), .mean(mean), .min(min), .max(max),
    .valid(valid), .overrun(overrun), .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: list of samples of the open window plus held result
  int q[$];
  int m_n = 0;
  int m_sum = 0, m_mean = 0, m_min = 0, m_max = 0, m_cnt = 0;
  bit m_valid = 0, m_over = 0;
  int s, lo, hi, d, avg;
  bit fin;

  function automatic int mm(input int v);
`ifdef LOCK_STATS_MINMAX_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_sum = 0; m_mean = 0; m_min = 0; m_max = 0; m_cnt = 0;
      m_valid = 0; m_over = 0;
    end else if (clear) begin
      q.delete();
      m_sum = 0; m_mean = 0; m_min = 0; m_max = 0; m_cnt = 0;
      m_valid = 0; m_over = 0;
    end else begin
      fin = 0;
      if (in_tick) begin
        if (q.size() == 0) m_n = (int'(log2_win) > M) ? M : int'(log2_win);
        q.push_back(int'(in_v));
        if (q.size() == (1 << m_n)) begin
          s = 0; lo = q[0]; hi = q[0];
          foreach (q[i]) begin
            s += q[i];
            if (q[i] < lo) lo = q[i];
            if (q[i] > hi) hi = q[i];
          end
          d = 1 << m_n;
          avg = (s >= 0) ? s / d : -((-s + d - 1) / d);
          fin = 1;
          q.delete();
        end
      end
      if (fin) begin
        if (!m_valid || ack) begin
          m_sum = s; m_mean = avg; m_min = lo; m_max = hi;
          m_valid = 1; m_cnt = (m_cnt + 1) % 256;
        end else begin
          m_over = 1;
        end
      end else if (ack) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_sum", int'(sum), m_sum);
    chk("cyc_mean", int'(mean), m_mean);
    chk("cyc_min", int'(min), mm(m_min));
    chk("cyc_max", int'(max), mm(m_max));
    chk("cyc_valid", int'(valid), int'(m_valid));
    chk("cyc_overrun", int'(overrun), int'(m_over));
    chk("cyc_win_cnt", int'(win_cnt), m_cnt);
  end

  task automatic cyc(input bit t, input int v, input bit a, input bit c);
    in_tick = t;
    in_v = v[R-1:0];
    ack = a;
    clear = c;
    @(negedge clk);
    in_tick = 0;
    ack = 0;
    clear = 0;
  endtask

  initial begin
    int v, r;
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_win_cnt", int'(win_cnt), 0);
    rst_n = 1;
    @(negedge clk);

    // window of 4: 1,2,3,4
    log2_win = 2;
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0);
    chk("w4_valid_early", int'(valid), 0);
    cyc(1, 4, 0, 0);
    chk("w4_sum", int'(sum), 10);
    chk("w4_mean", int'(mean), 2);
    chk("w4_min", int'(min), mm(1));
    chk("w4_max", int'(max), mm(4));
    chk("w4_valid", int'(valid), 1);
    chk("w4_win_cnt", int'(win_cnt), 1);
    cyc(0, 0, 1, 0);
    chk("ack_clears_valid", int'(valid), 0);

    // window of 2, negative floor mean
    log2_win = 1;
    cyc(1, -3, 0, 0); cyc(1, -4, 0, 0);
    chk("w2_sum", int'(sum), -7);
    chk("w2_mean", int'(mean), -4);
    chk("w2_min", int'(min), mm(-4));
    chk("w2_max", int'(max), mm(-3));
    chk("w2_win_cnt", int'(win_cnt), 2);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("clear_win_cnt", int'(win_cnt), 0);

    // overrun: n=0, no ack
    log2_win = 0;
    cyc(1, 5, 0, 0); cyc(1, 6, 0, 0);
    chk("ovr_mean", int'(mean), 5);
    chk("ovr_sum", int'(sum), 5);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_valid", int'(valid), 1);
    chk("ovr_win_cnt", int'(win_cnt), 1);
    cyc(0, 0, 0, 1);
    chk("clear_overrun", int'(overrun), 0);

    // completion with ack in same cycle
    cyc(1, 5, 0, 0); cyc(1, 6, 1, 0);
    chk("ackc_mean", int'(mean), 6);
    chk("ackc_valid", int'(valid), 1);
    chk("ackc_overrun", int'(overrun), 0);
    chk("ackc_win_cnt", int'(win_cnt), 2);
    cyc(0, 0, 0, 1);

    // log2_win=7 clamps to 16; mid-window change must not matter
    log2_win = 7;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 100, 0, 0);
      if (i == 0) log2_win = 0;
      if (i == 14) chk("w16_valid_early", int'(valid), 0);
      if (i == 15) begin
        chk("w16_sum", int'(sum), 1600);
        chk("w16_mean", int'(mean), 100);
        chk("w16_valid", int'(valid), 1);
      end
      cyc(0, 0, 0, 0);
    end

    // reset mid-window, result still held
    log2_win = 2;
    cyc(1, 50, 0, 0); cyc(1, 50, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_sum", int'(sum), 0);
    chk("async_rst_win_cnt", int'(win_cnt), 0);
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) cyc(1, 8, 0, 0);
    chk("post_rst_sum", int'(sum), 32);
    chk("post_rst_mean", int'(mean), 8);
    chk("post_rst_win_cnt", int'(win_cnt), 1);
    cyc(0, 0, 1, 0);

    // win_cnt wrap
    cyc(0, 0, 0, 1);
    log2_win = 0;
    for (int i = 0; i < 260; i++) cyc(1, i, 1, 0);
    chk("wrap_win_cnt", int'(win_cnt), 4);
    cyc(0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 299);
      if (r == 0) begin
        #2 rst_n = 0;
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
      end else if (r < 3) begin
        cyc(0, 0, 0, 1);
      end else begin
        if (r < 20) log2_win = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
          0: v = -(1 << (R - 1));
          1: v = (1 << (R - 1)) - 1;
          default: v = $urandom_range(0, (1 << R) - 1);
        endcase
        cyc(1'($urandom_range(0, 1)), v, ($urandom_range(0, 3) == 0), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lock_stats.md
LOCK_STATS -- requirements
Module: lock_stats

Interface
REQ-001 SHALL have parameter R, default 14, sample width (matches upstream decimator mean width).
REQ-002 SHALL have parameter M, default 4, maximum log2 window length.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in  input  R  signed decimated sample (upstream mean).
REQ-006 SHALL have port in_tick  input  1  sample strobe, one cycle per new sample.
REQ-007 SHALL have port log2_win  input  3  requested window = 2**log2_win samples.
REQ-008 SHALL have port clear  input  1  synchronous flush of window, result and flags.
REQ-009 SHALL have port ack  input  1  consumer accepts held result.
REQ-010 SHALL have port sum  output  R+M  signed window sum.
REQ-011 SHALL have port mean  output  R  signed window mean.
REQ-012 SHALL have port min, max  output  R each  signed window extrema.
REQ-013 SHALL have port valid  output  1  result held, awaiting ack.
REQ-014 SHALL have port overrun  output  1  sticky, result dropped.
REQ-015 SHALL have port win_cnt  output  8  count of results emitted.

Function
REQ-016 SHALL use two states: ACC (accumulating) and FIRST (next in_tick starts a window); reset/clear enter FIRST.
REQ-017 SHALL latch n = min(log2_win, M) on the starting in_tick; log2_win changes mid-window take effect on the next window.
REQ-018 SHALL accumulate sign-extended in into an R+M accumulator on each in_tick; min/max track across the window; the starting sample loads all three.
REQ-019 SHALL complete a window on the in_tick that is sample 2**n; n=0 completes on every in_tick.
REQ-020 SHALL register sum, mean = sum arithmetic-shifted right by n (floor), min, max on completion, with valid=1 the next cycle (1-cycle latency).
REQ-021 SHALL begin the next window on the in_tick after completion with no lost samples.
REQ-022 SHALL hold outputs and valid unchanged while valid=1 and ack=0.
REQ-023 SHALL clear valid on ack when no completion occurs in that cycle.
REQ-024 SHALL, on completion with valid=1 and ack=0, discard the new result, keep held outputs, and set overrun.
REQ-025 SHALL, on completion with valid=1 and ack=1, load the new result and keep valid=1 without setting overrun.
REQ-026 SHALL increment win_cnt per loaded result, wrapping 255 to 0.
REQ-027 SHALL give clear priority over in_tick and ack: accumulator, valid, overrun and win_cnt go to 0 and the state to FIRST.
REQ-028 SHALL ignore in when in_tick=0.

Reset
REQ-029 SHALL, while rst_n=0, force sum, mean, min, max, valid, overrun, win_cnt and the accumulator to 0 and the state to FIRST, regardless of clk.
REQ-030 SHALL discard any partial window on reset asserted mid-window; the first in_tick after release starts a fresh window.

Configuration
REQ-031 SHALL compile min/max tracking only when LOCK_STATS_MINMAX_EN is defined.
REQ-032 SHALL, without LOCK_STATS_MINMAX_EN, drive min and max constant 0 and instantiate no comparators; all other behaviour is unchanged.

Structure
REQ-033 SHALL take the state encoding and the 3-bit window-field width from shared package lock_pkg.
REQ-034 SHALL put extrema tracking in sub-module lock_minmax (load, update, hold), instantiated only under LOCK_STATS_MINMAX_EN.

Verification
REQ-035 SHALL cover: log2_win=2, samples 1,2,3,4 -> sum=10, mean=2, min=1, max=4, valid=1 one cycle after the 4th tick, win_cnt=1.
REQ-036 SHALL cover: log2_win=1, samples -3,-4 -> sum=-7, mean=-4 (floor), min=-4, max=-3.
REQ-037 SHALL cover: log2_win=0, samples 5 then 6 with no ack -> outputs hold 5, overrun=1, win_cnt=1.
REQ-038 SHALL cover: log2_win=0, sample 5, then sample 6 with ack in the same cycle -> mean=6, valid=1, overrun=0, win_cnt=2.
REQ-039 SHALL cover: log2_win=7 (clamps to 4), 16 samples of 100 -> sum=1600, mean=100, valid after the 16th tick.
REQ-040 SHALL cover: rst_n low after 2 of 4 samples, then 4 samples of 8 -> sum=32, mean=8, no contribution from the earlier samples.
